// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: one pre-rotation register followed by one register per
// micro-rotation stage. Each sample selects rotation or vectoring mode on its own.
module cordic_pipe #(
    parameter int WIDTH  = 16,
    parameter int ANGW   = 16,
    parameter int STAGES = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic [ANGW-1:0]         z_in,
    output logic                    out_valid,
    output logic                    out_mode,
    output logic signed [WIDTH+1:0] x_out,
    output logic signed [WIDTH+1:0] y_out,
    output logic [ANGW-1:0]         z_out
);

    localparam int XW = WIDTH + 2;

    typedef logic [STAGES-1:0][ANGW-1:0] table_t;

    // atan(2^-i) in binary-angle units, built from the Taylor series in Q60 fixed point
    // and divided by 2*pi (Q60) pre-scaled to the angle width.
    function automatic table_t atan_table();
        table_t      t;
        logic [63:0] sum;
        logic [63:0] term;
        logic [63:0] den;
        int          sh;
        t   = '0;
        den = 64'h6487ED5110B4611A >> ANGW;
        for (int i = 0; i < STAGES; i++) begin
            if (i == 0) begin
                t[i] = ANGW'(1) << (ANGW - 3);
            end else begin
                sum = '0;
                for (int k = 0; k < 64; k++) begin
                    sh = 60 - i * (2 * k + 1);
                    if (sh >= 0) begin
                        term = (64'd1 << sh) / 64'(2 * k + 1);
                        if (k % 2 == 0) sum = sum + term;
                        else            sum = sum - term;
                    end
                end
                t[i] = ANGW'((sum + den / 2) / den);
            end
        end
        return t;
    endfunction

    localparam table_t ATAN = atan_table();

    // Index 0 is the pre-rotation register; index i+1 holds the result of stage i.
    logic signed [XW-1:0] x_r [0:STAGES];
    logic signed [XW-1:0] y_r [0:STAGES];
    logic [ANGW-1:0]      z_r [0:STAGES];
    logic signed [XW-1:0] x_n [0:STAGES];
    logic signed [XW-1:0] y_n [0:STAGES];
    logic [ANGW-1:0]      z_n [0:STAGES];
    logic [STAGES:0]      v_r;
    logic [STAGES:0]      m_r;

    logic signed [XW-1:0] x_ext;
    logic signed [XW-1:0] y_ext;
    logic                 flip;

    assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

    // Rotation folds angles outside [-90,+90) by 180 deg; vectoring folds the left half-plane.
    assign flip = in_mode ? x_ext[XW-1] : (z_in[ANGW-1] ^ z_in[ANGW-2]);

    always_comb begin
        logic signed [XW-1:0] x_sh;
        logic signed [XW-1:0] y_sh;
        logic                 d_pos;
        x_sh   = '0;
        y_sh   = '0;
        d_pos  = 1'b0;
        x_n[0] = flip ? -x_ext : x_ext;
        y_n[0] = flip ? -y_ext : y_ext;
        z_n[0] = flip ? {~z_in[ANGW-1], z_in[ANGW-2:0]} : z_in;
        for (int i = 0; i < STAGES; i++) begin
            d_pos = m_r[i] ? y_r[i][XW-1] : ~z_r[i][ANGW-1];
            x_sh  = x_r[i] >>> i;
            y_sh  = y_r[i] >>> i;
            if (d_pos) begin
                x_n[i+1] = x_r[i] - y_sh;
                y_n[i+1] = y_r[i] + x_sh;
                z_n[i+1] = z_r[i] - ATAN[i];
            end else begin
                x_n[i+1] = x_r[i] + y_sh;
                y_n[i+1] = y_r[i] - x_sh;
                z_n[i+1] = z_r[i] + ATAN[i];
            end
        end
    end

    // Handshake: no backpressure. A sample enters when en=1 and in_valid=1, and leaves
    // exactly STAGES+1 enabled cycles later with out_valid=1; en=0 freezes the whole pipe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= STAGES; i++) begin
                x_r[i] <= '0;
                y_r[i] <= '0;
                z_r[i] <= '0;
            end
            v_r <= '0;
            m_r <= '0;
        end else if (en) begin
            for (int i = 0; i <= STAGES; i++) begin
                x_r[i] <= x_n[i];
                y_r[i] <= y_n[i];
                z_r[i] <= z_n[i];
            end
            v_r <= {v_r[STAGES-1:0], in_valid};
            m_r <= {m_r[STAGES-1:0], in_mode};
        end
    end

    assign out_valid = v_r[STAGES];
    assign out_mode  = m_r[STAGES];
    assign x_out     = x_r[STAGES];
    assign y_out     = y_r[STAGES];
    assign z_out     = z_r[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// Scoreboard bench for cordic_pipe: directed vectors with hand-derived results, stall,
// mid-flight reset and the most negative vectoring corner.
module tb_cordic_pipe;

    localparam int WIDTH  = 16;
    localparam int ANGW   = 16;
    localparam int STAGES = 12;
    localparam int XW     = WIDTH + 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  en;
    logic                  in_valid;
    logic                  in_mode;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic [ANGW-1:0]       z_in;
    logic                  out_valid;
    logic                  out_mode;
    logic signed [XW-1:0]  x_out;
    logic signed [XW-1:0]  y_out;
    logic [ANGW-1:0]       z_out;

    typedef struct packed {
        logic mode;
        int   ex;
        int   ey;
        int   ez;
        int   y_tol;
        int   tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   en_cycles = 0;
    logic last_en = 1'b0;
    int   valid_count = 0;
    int   last_valid_cyc = 0;
    int   cyc_first;
    int   vc0;
    int   n;

    cordic_pipe #(.WIDTH(WIDTH), .ANGW(ANGW), .STAGES(STAGES)) dut (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_mode(in_mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_mode(out_mode),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    // ---------------- clock / reset block ----------------
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        last_en <= en;
        if (en) en_cycles <= en_cycles + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- comparison helpers ----------------
    task automatic check_val(input string name, input longint act, input longint exp, input longint tol);
        longint diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic check_ang(input string name, input longint act, input longint exp, input longint tol);
        logic signed [ANGW-1:0] d;
        longint diff;
        d = ANGW'(act - exp);
        diff = longint'(d);
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (tol %0d)", name, act, exp, tol);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic mode, input int x, input int y, input int z,
                        input int ex, input int ey, input int ez, input int y_tol);
        exp_t e;
        @(negedge clock);
        en       = 1'b1;
        in_valid = 1'b1;
        in_mode  = mode;
        x_in     = WIDTH'(x);
        y_in     = WIDTH'(y);
        z_in     = ANGW'(z);
        e.mode   = mode;
        e.ex     = ex;
        e.ey     = ey;
        e.ez     = ez;
        e.y_tol  = y_tol;
        e.tag    = en_cycles + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clock);
        en       = 1'b1;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        x_in     = '0;
        y_in     = '0;
        z_in     = '0;
    endtask

    // Stalled cycle with junk marked valid: nothing here may enter the pipe.
    task automatic stall();
        @(negedge clock);
        en       = 1'b0;
        in_valid = 1'b1;
        in_mode  = 1'($urandom_range(0, 1));
        x_in     = WIDTH'($urandom_range(0, 65535));
        y_in     = WIDTH'($urandom_range(0, 65535));
        z_in     = ANGW'($urandom_range(0, 65535));
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            idle();
            k++;
        end
        check_val("drain_pending", exp_q.size(), 0, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (!reset && out_valid && last_en) begin
            valid_count++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: out_valid=1 with no pending sample, x_out=%0d", x_out);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("latency", en_cycles, mon_e.tag + STAGES, 0);
                check_val("out_mode", out_mode, mon_e.mode, 0);
                check_val("x_out", x_out, mon_e.ex, 6);
                if (mon_e.y_tol != 0) check_val("y_out", y_out, mon_e.ey, mon_e.y_tol);
                check_ang("z_out", z_out, mon_e.ez, 4);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        en = 1'b1; in_valid = 1'b0; in_mode = 1'b0; x_in = '0; y_in = '0; z_in = '0;
        reset = 1'b1;
        #1;
        check_val("reset_out_valid", out_valid, 0, 0);
        check_val("reset_out_mode", out_mode, 0, 0);
        check_val("reset_x_out", x_out, 0, 0);
        check_val("reset_y_out", y_out, 0, 0);
        check_val("reset_z_out", z_out, 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 45 deg rotation and vectoring of (10000,10000); K = 1.64676
        send(1'b0, 10000, 0, 'h2000, 11644, 11644, 0, 6);
        drain(40);
        send(1'b1, 10000, 10000, 0, 23289, 0, 'h2000, 6);
        drain(40);
        // Pre-rotation: 180 deg rotation, vectoring from the left half-plane.
        // A residual angle of a few LSB at |x|=16468 moves y by several LSB, hence the wider y tolerance.
        send(1'b0, 10000, 0, 'h8000, -16468, 0, 0, 10);
        drain(40);
        send(1'b1, -10000, 0, 0, 16468, 0, 'h8000, 10);
        drain(40);

        // Alternating modes with a 3-cycle stall after the second sample
        vc0 = valid_count;
        send(1'b0, 10000, 0, 'h2000, 11644, 11644, 0, 6);
        cyc_first = cyc + 1;
        send(1'b1, 10000, 10000, 0, 23289, 0, 'h2000, 6);
        stall(); stall(); stall();
        send(1'b0, 10000, 0, 'h8000, -16468, 0, 0, 10);
        send(1'b1, -10000, 0, 0, 16468, 0, 'h8000, 10);
        send(1'b0, 10000, 0, 'h2000, 11644, 11644, 0, 6);
        drain(40);
        check_val("stream_valid_pulses", valid_count - vc0, 5, 0);
        // Cycle 1 is the one in which the first sample is presented; outputs appear the cycle after their edge.
        check_val("stream_last_cycle", last_valid_cyc - cyc_first + 2, 5 + 13 + 3, 0);

        // Reset with four samples in flight while a vectoring result sits at the output
        send(1'b1, 10000, 10000, 0, 23289, 0, 'h2000, 6);
        repeat (8) idle();
        send(1'b0, 10000, 0, 'h2000, 11644, 11644, 0, 6);
        send(1'b0, 10000, 0, 'h8000, -16468, 0, 0, 10);
        send(1'b0, 10000, 0, 'h2000, 11644, 11644, 0, 6);
        send(1'b0, 10000, 0, 'h8000, -16468, 0, 0, 10);
        idle();
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_val("pre_reset_out_valid", out_valid, 1, 0);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_val("midreset_out_valid", out_valid, 0, 0);
        check_val("midreset_out_mode", out_mode, 0, 0);
        check_val("midreset_x_out", x_out, 0, 0);
        check_val("midreset_y_out", y_out, 0, 0);
        check_val("midreset_z_out", z_out, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        vc0 = valid_count;
        repeat (20) idle();
        check_val("post_reset_quiet", valid_count - vc0, 0, 0);

        // Most negative corner: magnitude 32768*sqrt(2)*K, angle -135 deg
        send(1'b1, -32768, -32768, 0, 76312, 0, 'hA000, 0);
        drain(40);

        check_val("queue_empty_at_end", exp_q.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
